// File: rtl/traffic_intersection_ctrl_if.sv
// Lamp/request bundle between the intersection phase scheduler and its environment.
// master = scheduler side, slave = sensors/lamp drivers side.
interface traffic_intersection_ctrl_if;
  logic       side_req;
  logic       ped_req;
  logic       main_r;
  logic       main_y;
  logic       main_g;
  logic       side_r;
  logic       side_y;
  logic       side_g;
  logic       ped_walk;
  logic [2:0] phase;

  modport master (
    input  side_req, ped_req,
    output main_r, main_y, main_g, side_r, side_y, side_g, ped_walk, phase
  );

  modport slave (
    output side_req, ped_req,
    input  main_r, main_y, main_g, side_r, side_y, side_g, ped_walk, phase
  );
endinterface

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection phase scheduler: one registered phase FSM plus one down-counter.
// Define PED_INTERSECTION_EN to enable the pedestrian latch, PED_WALK phase and walk lamp.
module traffic_intersection_ctrl #(
  parameter int TW       = 8,
  parameter int MAIN_MIN = 10,
  parameter int YEL      = 3,
  parameter int ALLRED   = 2,
  parameter int SIDE_GRN = 6,
  parameter int WALK     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  traffic_intersection_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_MAIN_GRN = 3'd0,
    S_MAIN_YEL = 3'd1,
    S_ALLRED_1 = 3'd2,
    S_SIDE_GRN = 3'd3,
    S_SIDE_YEL = 3'd4,
    S_ALLRED_2 = 3'd5,
    S_PED_WALK = 3'd6,
    S_ILLEGAL  = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ped_pend_q, ped_pend_d;
  logic          timer_done;

  logic main_r, main_y, main_g, side_r, side_y, side_g, ped_walk;

  // Load value is duration-1 so a state lasts exactly its duration.
  function automatic logic [TW-1:0] dur_ld(input state_e s);
    case (s)
      S_MAIN_GRN: dur_ld = TW'(MAIN_MIN - 1);
      S_MAIN_YEL: dur_ld = TW'(YEL - 1);
      S_SIDE_GRN: dur_ld = TW'(SIDE_GRN - 1);
      S_SIDE_YEL: dur_ld = TW'(YEL - 1);
      S_PED_WALK: dur_ld = TW'(WALK - 1);
      default:    dur_ld = TW'(ALLRED - 1);
    endcase
  endfunction

  assign timer_done = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MAIN_GRN: if (timer_done && (bus.side_req || ped_pend_q)) state_d = S_MAIN_YEL;
      S_MAIN_YEL: if (timer_done) state_d = S_ALLRED_1;
      // Committed once here: with no request left we still serve the side road.
      S_ALLRED_1: if (timer_done) state_d = ped_pend_q ? S_PED_WALK : S_SIDE_GRN;
      S_SIDE_GRN: if (timer_done) state_d = S_SIDE_YEL;
      S_SIDE_YEL: if (timer_done) state_d = S_ALLRED_2;
      S_ALLRED_2: if (timer_done) state_d = S_MAIN_GRN;
`ifdef PED_INTERSECTION_EN
      S_PED_WALK: if (timer_done) state_d = S_ALLRED_2;
`else
      S_PED_WALK: state_d = S_ALLRED_2;
`endif
      default:    state_d = S_ALLRED_2;
    endcase
  end

  // Reload on every state change; otherwise count down and saturate at zero.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)  timer_d = dur_ld(state_d);
    else if (!timer_done)    timer_d = timer_q - TW'(1);
  end

`ifdef PED_INTERSECTION_EN
  // Entering the walk clears the latch and beats a same-cycle press.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (state_d == S_PED_WALK && state_q != S_PED_WALK)  ped_pend_d = 1'b0;
    else if (bus.ped_req && state_q != S_PED_WALK)       ped_pend_d = 1'b1;
  end
`else
  logic ped_req_unused;
  assign ped_req_unused = bus.ped_req;

  always_comb begin
    ped_pend_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ALLRED_2;
      timer_q    <= TW'(ALLRED - 1);
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  // Moore decode; anything not a main/side phase shows red on that road.
  always_comb begin
    main_r   = 1'b1;
    main_y   = 1'b0;
    main_g   = 1'b0;
    side_r   = 1'b1;
    side_y   = 1'b0;
    side_g   = 1'b0;
    ped_walk = 1'b0;
    case (state_q)
      S_MAIN_GRN: begin main_r = 1'b0; main_g = 1'b1; end
      S_MAIN_YEL: begin main_r = 1'b0; main_y = 1'b1; end
      S_SIDE_GRN: begin side_r = 1'b0; side_g = 1'b1; end
      S_SIDE_YEL: begin side_r = 1'b0; side_y = 1'b1; end
`ifdef PED_INTERSECTION_EN
      S_PED_WALK: ped_walk = 1'b1;
`endif
      default: ;
    endcase
  end

  assign bus.main_r   = main_r;
  assign bus.main_y   = main_y;
  assign bus.main_g   = main_g;
  assign bus.side_r   = side_r;
  assign bus.side_y   = side_y;
  assign bus.side_g   = side_g;
  assign bus.ped_walk = ped_walk;
  assign bus.phase    = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench for traffic_intersection_ctrl: per-cycle stimulus and expected phases are
// queued together, then popped and compared cycle by cycle (phase and full lamp vector).
module tb_traffic_intersection_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_intersection_ctrl_if bus ();

  traffic_intersection_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] exp_q[$];   // expected phase per cycle
  logic [2:0] stim_q[$];  // {rst, side_req, ped_req} per cycle
  logic [2:0] exp_ph;
  logic [2:0] st;
  logic [6:0] lamps;

  assign lamps = {bus.main_r, bus.main_y, bus.main_g, bus.side_r, bus.side_y, bus.side_g, bus.ped_walk};

  // {main_r,main_y,main_g,side_r,side_y,side_g,ped_walk} for each legal phase.
  function automatic logic [6:0] lamp_of(input logic [2:0] ph);
    case (ph)
      3'd0:    lamp_of = 7'b0011000;
      3'd1:    lamp_of = 7'b0101000;
      3'd3:    lamp_of = 7'b1000010;
      3'd4:    lamp_of = 7'b1000100;
      3'd6:    lamp_of = 7'b1001001;
      default: lamp_of = 7'b1001000;
    endcase
  endfunction

  task automatic push(input logic [2:0] ph, input int n, input logic [2:0] s);
    repeat (n) begin
      exp_q.push_back(ph);
      stim_q.push_back(s);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.side_req = 1'b0; bus.ped_req = 1'b0;
    exp_q.delete(); stim_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.side_req = 1'b1; bus.ped_req = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (bus.phase !== 3'd5) begin n_fail++; $display("FAIL reset_phase got %0d want 5", bus.phase); end
      n_tests++;
      if (lamps !== 7'b1001000) begin n_fail++; $display("FAIL reset_lamps got %b want 1001000", lamps); end
    end
  endtask

  task automatic test_idle_main();
    do_reset();
    push(3'd5, 2, 3'b000);
    push(3'd0, 58, 3'b000);
    for (int k = 0; exp_q.size() > 0; k++) begin
      st = stim_q.pop_front(); rst = st[2]; bus.side_req = st[1]; bus.ped_req = st[0];
      @(negedge clk);
      exp_ph = exp_q.pop_front();
      n_tests++;
      if (bus.phase !== exp_ph) begin n_fail++; $display("FAIL idle_phase cyc %0d got %0d want %0d", k, bus.phase, exp_ph); end
      n_tests++;
      if (lamps !== lamp_of(exp_ph)) begin n_fail++; $display("FAIL idle_lamps cyc %0d got %b want %b", k, lamps, lamp_of(exp_ph)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_side_cycle();
    do_reset();
    push(3'd5, 2, 3'b010); push(3'd0, 10, 3'b010); push(3'd1, 3, 3'b010);
    push(3'd2, 2, 3'b010); push(3'd3, 6, 3'b010); push(3'd4, 3, 3'b010);
    push(3'd5, 2, 3'b010); push(3'd0, 10, 3'b010); push(3'd1, 3, 3'b010);
    for (int k = 0; exp_q.size() > 0; k++) begin
      st = stim_q.pop_front(); rst = st[2]; bus.side_req = st[1]; bus.ped_req = st[0];
      @(negedge clk);
      exp_ph = exp_q.pop_front();
      n_tests++;
      if (bus.phase !== exp_ph) begin n_fail++; $display("FAIL side_phase cyc %0d got %0d want %0d", k, bus.phase, exp_ph); end
      n_tests++;
      if (lamps !== lamp_of(exp_ph)) begin n_fail++; $display("FAIL side_lamps cyc %0d got %b want %b", k, lamps, lamp_of(exp_ph)); end
      @(posedge clk); #1;
    end
  endtask

  // Request after the minimum green has expired: leaves main green on the very next edge.
  task automatic test_late_request();
    do_reset();
    push(3'd5, 2, 3'b000); push(3'd0, 39, 3'b000); push(3'd1, 3, 3'b000);
    push(3'd2, 2, 3'b000); push(3'd3, 6, 3'b000); push(3'd4, 3, 3'b000);
    push(3'd5, 2, 3'b000); push(3'd0, 4, 3'b000);
    stim_q[40] = 3'b010;
    for (int k = 0; exp_q.size() > 0; k++) begin
      st = stim_q.pop_front(); rst = st[2]; bus.side_req = st[1]; bus.ped_req = st[0];
      @(negedge clk);
      exp_ph = exp_q.pop_front();
      n_tests++;
      if (bus.phase !== exp_ph) begin n_fail++; $display("FAIL late_phase cyc %0d got %0d want %0d", k, bus.phase, exp_ph); end
      n_tests++;
      if (lamps !== lamp_of(exp_ph)) begin n_fail++; $display("FAIL late_lamps cyc %0d got %b want %b", k, lamps, lamp_of(exp_ph)); end
      @(posedge clk); #1;
    end
  endtask

`ifdef PED_INTERSECTION_EN
  // Single press at cycle 3; presses during the walk itself must not re-latch.
  task automatic test_ped_walk();
    do_reset();
    push(3'd5, 2, 3'b000); push(3'd0, 10, 3'b000); push(3'd1, 3, 3'b000);
    push(3'd2, 2, 3'b000); push(3'd6, 8, 3'b000); push(3'd5, 2, 3'b000);
    push(3'd0, 12, 3'b000);
    stim_q[3] = 3'b001; stim_q[20] = 3'b001; stim_q[24] = 3'b001;
    for (int k = 0; exp_q.size() > 0; k++) begin
      st = stim_q.pop_front(); rst = st[2]; bus.side_req = st[1]; bus.ped_req = st[0];
      @(negedge clk);
      exp_ph = exp_q.pop_front();
      n_tests++;
      if (bus.phase !== exp_ph) begin n_fail++; $display("FAIL ped_phase cyc %0d got %0d want %0d", k, bus.phase, exp_ph); end
      n_tests++;
      if (lamps !== lamp_of(exp_ph)) begin n_fail++; $display("FAIL ped_lamps cyc %0d got %b want %b", k, lamps, lamp_of(exp_ph)); end
      @(posedge clk); #1;
    end
  endtask
`endif

  // Pedestrian and side request together: walk first, side on the next main exit.
  task automatic test_ped_and_side();
    do_reset();
`ifdef PED_INTERSECTION_EN
    push(3'd5, 2, 3'b010); push(3'd0, 10, 3'b010); push(3'd1, 3, 3'b010);
    push(3'd2, 2, 3'b010); push(3'd6, 8, 3'b010); push(3'd5, 2, 3'b010);
    push(3'd0, 10, 3'b010); push(3'd1, 3, 3'b010); push(3'd2, 2, 3'b010);
    push(3'd3, 6, 3'b010); push(3'd4, 3, 3'b010); push(3'd5, 2, 3'b010);
    push(3'd0, 2, 3'b010);
`else
    push(3'd5, 2, 3'b010); push(3'd0, 10, 3'b010); push(3'd1, 3, 3'b010);
    push(3'd2, 2, 3'b010); push(3'd3, 6, 3'b010); push(3'd4, 3, 3'b010);
    push(3'd5, 2, 3'b010); push(3'd0, 10, 3'b010); push(3'd1, 3, 3'b010);
`endif
    stim_q[0] = 3'b011;
    for (int k = 0; exp_q.size() > 0; k++) begin
      st = stim_q.pop_front(); rst = st[2]; bus.side_req = st[1]; bus.ped_req = st[0];
      @(negedge clk);
      exp_ph = exp_q.pop_front();
      n_tests++;
      if (bus.phase !== exp_ph) begin n_fail++; $display("FAIL both_phase cyc %0d got %0d want %0d", k, bus.phase, exp_ph); end
      n_tests++;
      if (lamps !== lamp_of(exp_ph)) begin n_fail++; $display("FAIL both_lamps cyc %0d got %b want %b", k, lamps, lamp_of(exp_ph)); end
      @(posedge clk); #1;
    end
  endtask

  // One-cycle reset in side green (with a pending walk press): all-red, then main holds.
  task automatic test_mid_reset();
    do_reset();
    push(3'd5, 2, 3'b010); push(3'd0, 10, 3'b010); push(3'd1, 3, 3'b010);
    push(3'd2, 2, 3'b010); push(3'd3, 3, 3'b010); push(3'd5, 2, 3'b000);
    push(3'd0, 15, 3'b000);
    stim_q[18] = 3'b011; stim_q[19] = 3'b100;
    for (int k = 0; exp_q.size() > 0; k++) begin
      st = stim_q.pop_front(); rst = st[2]; bus.side_req = st[1]; bus.ped_req = st[0];
      @(negedge clk);
      exp_ph = exp_q.pop_front();
      n_tests++;
      if (bus.phase !== exp_ph) begin n_fail++; $display("FAIL mrst_phase cyc %0d got %0d want %0d", k, bus.phase, exp_ph); end
      n_tests++;
      if (lamps !== lamp_of(exp_ph)) begin n_fail++; $display("FAIL mrst_lamps cyc %0d got %b want %b", k, lamps, lamp_of(exp_ph)); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.side_req = 1'b0;
    bus.ped_req  = 1'b0;
    test_reset();
    test_idle_main();
    test_side_cycle();
    test_late_request();
`ifdef PED_INTERSECTION_EN
    test_ped_walk();
`endif
    test_ped_and_side();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
